// File: rtl/idct2d_if.sv
// Coefficient/step/basis read ports, sample write port and start handshake
// for the 8x8 inverse DCT block.
interface idct2d_if #(
    parameter int W  = 16,
    parameter int CW = 16
) ();
    logic                 rdy;
    logic                 en;
    logic [5:0]           iaddr;
    logic signed [W-1:0]  iq;
    logic [5:0]           maddr;
    logic signed [W-1:0]  mq;
    logic [5:0]           baddr;
    logic signed [CW-1:0] bq;
    logic [5:0]           waddr;
    logic signed [W-1:0]  wdata;
    logic                 wwren;

    modport slave (
        output rdy, iaddr, maddr, baddr, waddr, wdata, wwren,
        input  en, iq, mq, bq
    );

    modport master (
        input  rdy, iaddr, maddr, baddr, waddr, wdata, wwren,
        output en, iq, mq, bq
    );
endinterface

// File: rtl/idct2d.sv
// Dequantizer plus separable 8x8 inverse DCT (row pass, then column pass)
// built around one shared signed multiplier and an external basis ROM.
module idct2d #(
    parameter int W    = 16,
    parameter int CW   = 16,
    parameter int FRAC = 14,
    parameter int ACCW = 36
) (
    input  logic    clk,
    input  logic    reset,
    idct2d_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, ROW, COL} state_t;

    localparam logic signed [ACCW-1:0] HI =
        (ACCW'(1) <<< (W-1)) - ACCW'(1);
    localparam logic signed [ACCW-1:0] LO = ~HI;
    localparam logic signed [ACCW-1:0] HALF =
        ACCW'(1) <<< (FRAC-1);

    state_t state, state_n;
    logic [6:0] cnt;
    logic [3:0] k;
    logic [5:0] e;

    logic signed [W-1:0] a_buf [64];
    logic signed [W-1:0] t_buf [64];
    logic signed [W-1:0] opa, op_sel, mul_a, rnd_v;
    logic signed [CW-1:0] mul_b;
    logic signed [W+CW-1:0] prod;
    logic signed [ACCW-1:0] prod_x, acc;
    logic mac, issue, slot_end;
    logic [2:0] bsel;
    logic wwren_q;
    logic [5:0] waddr_q;
    logic signed [W-1:0] wdata_q;

    function automatic logic signed [W-1:0] sat(
        input logic signed [ACCW-1:0] x
    );
        logic signed [W-1:0] r;
        r = x[W-1:0];
        if (x > HI)
            r = HI[W-1:0];
        else if (x < LO)
            r = LO[W-1:0];
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (bus.en) state_n = LOAD;
            LOAD: if (cnt == 7'd64) state_n = ROW;
            ROW:  if (slot_end && e == 6'd63) state_n = COL;
            COL:  if (slot_end && e == 6'd63) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        mac      = (state == ROW) || (state == COL);
        issue    = mac && !k[3];
        slot_end = mac && (k == 4'd9);
        bsel     = (state == ROW) ? e[2:0] : e[5:3];
        op_sel   = (state == ROW) ? a_buf[{e[5:3], k[2:0]}]
                                  : t_buf[{k[2:0], e[2:0]}];
        mul_a    = (state == LOAD) ? bus.iq : opa;
        mul_b    = (state == LOAD) ? CW'(bus.mq) : bus.bq;
    end

    assign prod   = mul_a * mul_b;
    assign prod_x = ACCW'(prod);
    assign rnd_v  = sat((acc + HALF) >>> FRAC);

    // e wraps 63 -> 0 at the ROW/COL boundary, so COL restarts at element 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            k   <= '0;
            e   <= '0;
        end else begin
            cnt <= (state == LOAD) ? cnt + 7'd1 : 7'd0;
            if (mac) begin
                k <= (k == 4'd9) ? 4'd0 : k + 4'd1;
                if (k == 4'd9)
                    e <= e + 6'd1;
            end else begin
                k <= '0;
                e <= '0;
            end
        end
    end

    // slot: k=0..7 issue, operand/ROM data land one cycle later, k=9 rounds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opa     <= '0;
            acc     <= '0;
            wwren_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wwren_q <= 1'b0;
            if (issue)
                opa <= op_sel;
            if (mac && k == 4'd1)
                acc <= prod_x;
            else if (mac && k >= 4'd2 && k <= 4'd8)
                acc <= acc + prod_x;
            if (state == COL && slot_end) begin
                wwren_q <= 1'b1;
                waddr_q <= e;
                wdata_q <= rnd_v;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && cnt != 7'd0)
            a_buf[6'(cnt - 7'd1)] <= sat(prod_x);
        if (state == ROW && slot_end)
            t_buf[e] <= rnd_v;
    end

    assign bus.rdy   = (state == IDLE);
    assign bus.iaddr = (state == LOAD) ? cnt[5:0] : 6'd0;
    assign bus.maddr = bus.iaddr;
    assign bus.baddr = issue ? {k[2:0], bsel} : 6'd0;
    assign bus.wwren = wwren_q;
    assign bus.waddr = wwren_q ? waddr_q : 6'd0;
    assign bus.wdata = wdata_q;
endmodule
